// File: rtl/bitbang_tx_if.sv
// Word handshake between a configuration source and the bit-bang serializer.
//   word_data  : 32-bit configuration word (source -> serializer)
//   word_valid : word_data is valid (source -> serializer)
//   word_ready : serializer is idle and will take the word (serializer -> source)
interface bitbang_tx_if;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/bitbang_tx.sv
// Host-side serializer for the fabric configuration bit-bang port.
// Each accepted 32-bit word is shifted out MSB first, followed by the 16-bit
// CTRL_WORD trailer that commits it, as a 48-bit frame on s_clk/s_data.
// s_data changes only while s_clk is low, so it is stable for CLK_DIV cycles
// around every s_clk rising edge, which is where the receiver samples.
// Ports:
//   CLK, reset  : system clock (rising edge), asynchronous active-high reset
//   wordIf      : word_data / word_valid / word_ready handshake (slave side)
//   s_clk       : bit-bang clock to the fabric
//   s_data      : bit-bang data to the fabric
//   busy        : frame or trailing gap in progress (always ~word_ready)
//   words_sent  : completed frames, wraps modulo 2^16
module bitbang_tx #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [15:0] CTRL_WORD  = 16'hFAB1
) (
  input  logic        CLK,
  input  logic        reset,
  bitbang_tx_if.slave wordIf,
  output logic        s_clk,
  output logic        s_data,
  output logic        busy,
  output logic [15:0] words_sent
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} stateT;

  stateT             state, stateNxt;
  logic [DIV_W-1:0]  divCnt;
  logic [GAP_W-1:0]  gapCnt;
  logic [5:0]        bitIdx;
  logic [47:0]       shiftReg, shiftNxt;
  logic              sClkNxt, sDataNxt, readyNxt;

  // word_ready is only high in IDLE, so accept implies IDLE
  logic accept, divLast, gapLast, bitStep, lastBit;
  assign accept  = wordIf.word_valid && wordIf.word_ready;
  assign divLast = (divCnt == DIV_LAST);
  assign gapLast = (gapCnt == GAP_LAST);
  assign bitStep = (state == HIGH) && divLast;
  assign lastBit = (bitIdx == 6'd0);

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNxt;
  end

  // Next-state logic
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: if (accept) stateNxt = LOW;
      LOW:  if (divLast) stateNxt = HIGH;
      HIGH: if (divLast) begin
              if (!lastBit)             stateNxt = LOW;
              else if (GAP_CYCLES == 0) stateNxt = IDLE;
              else                      stateNxt = GAP;
            end
      GAP:  if (gapLast) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Frame shifter: load on accept, advance when a bit's high phase ends
  always_comb begin
    shiftNxt = shiftReg;
    if (accept)                 shiftNxt = {wordIf.word_data, CTRL_WORD};
    else if (bitStep && !lastBit) shiftNxt = {shiftReg[46:0], 1'b0};
  end

  // Output logic, evaluated on the next state so the pins come straight
  // from flops and s_data moves together with the falling s_clk
  always_comb begin
    sClkNxt  = (stateNxt == HIGH);
    sDataNxt = ((stateNxt == LOW) || (stateNxt == HIGH)) ? shiftNxt[47] : 1'b0;
    readyNxt = (stateNxt == IDLE);
  end

  // Counters and datapath
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      divCnt     <= '0;
      gapCnt     <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      words_sent <= '0;
    end else begin
      // divide counter restarts on every LOW/HIGH phase change
      divCnt   <= ((stateNxt == state) && ((state == LOW) || (state == HIGH)))
                  ? divCnt + 1'b1 : '0;
      gapCnt   <= ((state == GAP) && (stateNxt == GAP)) ? gapCnt + 1'b1 : '0;
      shiftReg <= shiftNxt;
      if (accept)                   bitIdx <= 6'd47;
      else if (bitStep && !lastBit) bitIdx <= bitIdx - 6'd1;
      if (bitStep && lastBit)       words_sent <= words_sent + 16'd1;
    end
  end

  // Registered outputs
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      s_clk             <= 1'b0;
      s_data            <= 1'b0;
      wordIf.word_ready <= 1'b1;
      busy              <= 1'b0;
    end else begin
      s_clk             <= sClkNxt;
      s_data            <= sDataNxt;
      wordIf.word_ready <= readyNxt;
      busy              <= !readyNxt;
    end
  end

endmodule

// File: tb/tb_bitbang_tx.sv
// Bench for bitbang_tx: two instances (CLK_DIV=2/GAP=4 and CLK_DIV=1/GAP=0)
// checked every cycle against a timing model derived from accept time and
// frame contents, plus directed literal checks on decoded frames and latencies.
module tb_bitbang_tx;
  localparam int DA = 2, GA = 4, DB = 1, GB = 0;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;  // number of rising edges so far

  logic [1:0]  vld;
  logic [31:0] dat [2];
  logic [1:0]  rdy, sClk, sDat, bsy;
  logic [15:0] ws [2];
  logic [15:0] cntBias [2];

  bitbang_tx_if ifA ();
  bitbang_tx_if ifB ();
  assign ifA.word_valid = vld[0];
  assign ifA.word_data  = dat[0];
  assign ifB.word_valid = vld[1];
  assign ifB.word_data  = dat[1];
  assign rdy[0] = ifA.word_ready;
  assign rdy[1] = ifB.word_ready;

  bitbang_tx #(.CLK_DIV(DA), .GAP_CYCLES(GA), .CTRL_WORD(16'hFAB1)) dutA (
    .CLK(CLK), .reset(reset), .wordIf(ifA),
    .s_clk(sClk[0]), .s_data(sDat[0]), .busy(bsy[0]), .words_sent(ws[0]));
  bitbang_tx #(.CLK_DIV(DB), .GAP_CYCLES(GB), .CTRL_WORD(16'hFAB1)) dutB (
    .CLK(CLK), .reset(reset), .wordIf(ifB),
    .s_clk(sClk[1]), .s_data(sDat[1]), .busy(bsy[1]), .words_sent(ws[1]));

  function automatic int dv(int i); return (i == 0) ? DA : DB; endfunction
  function automatic int gv(int i); return (i == 0) ? GA : GB; endfunction

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: a frame started at edge T owns the next 96*D+G edges
  logic        mAct [2];
  int          mT [2];
  logic [47:0] mFrame [2];
  logic [15:0] mCnt [2];

  always @(posedge CLK) begin
    ecnt <= ecnt + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mAct[i] <= 1'b0;
        mCnt[i] <= 16'h0;
      end else if (!mAct[i]) begin
        if (vld[i]) begin
          mAct[i]   <= 1'b1;
          mT[i]     <= ecnt + 1;
          mFrame[i] <= {dat[i], 16'hFAB1};
        end
      end else begin
        if (ecnt + 1 - mT[i] == 96 * dv(i)) mCnt[i] <= mCnt[i] + 16'd1;
        if (ecnt + 1 - mT[i] >= 96 * dv(i) + gv(i)) mAct[i] <= 1'b0;
      end
    end
  end

  task automatic cmpDut(int i);
    int m, d;
    logic eC, eD, eR;
    logic [15:0] eW;
    d  = dv(i);
    eW = reset ? 16'h0 : mCnt[i] + cntBias[i];
    eC = 1'b0; eD = 1'b0; eR = 1'b1;
    if (!reset && mAct[i]) begin
      eR = 1'b0;
      m  = ecnt - mT[i];
      if (m < 96 * d) begin
        eC = (m % (2 * d)) >= d;
        eD = mFrame[i][47 - m / (2 * d)];
      end
    end
    chk($sformatf("e%0d.u%0d.word_ready", ecnt, i), rdy[i], eR);
    chk($sformatf("e%0d.u%0d.busy", ecnt, i), bsy[i], !eR);
    chk($sformatf("e%0d.u%0d.s_clk", ecnt, i), sClk[i], eC);
    chk($sformatf("e%0d.u%0d.s_data", ecnt, i), sDat[i], eD);
    chk($sformatf("e%0d.u%0d.words_sent", ecnt, i), ws[i], eW);
  endtask

  always @(negedge CLK) begin
    cmpDut(0);
    cmpDut(1);
  end

  // Wait for word_ready, then the next rising edge is the accept edge
  task automatic waitAccept(int i, output int t);
    t = -1;
    for (int n = 0; n < 2000; n++) begin
      if (rdy[i]) begin
        @(posedge CLK); #1;
        t = ecnt;
        return;
      end
      @(negedge CLK);
    end
    chk($sformatf("u%0d.accept_timeout", i), 0, 1);
  endtask

  task automatic sendWord(int i, logic [31:0] w, output int t);
    vld[i] = 1'b1;
    dat[i] = w;
    waitAccept(i, t);
    vld[i] = 1'b0;
  endtask

  // Follow one frame until word_ready returns: decode bits on s_clk rises
  task automatic measure(int i, bit scr, output logic [47:0] dec, output int nRise,
                         output int fr, output int ce, output int re, output int zc);
    logic pc;
    logic [15:0] w0;
    dec = '0; nRise = 0; fr = -1; ce = -1; re = -1; zc = 0;
    pc = sClk[i]; w0 = ws[i];
    for (int n = 0; n < 1000; n++) begin
      @(negedge CLK);
      if (scr) dat[i] = $urandom;
      if (sClk[i] && !pc) begin
        dec = {dec[46:0], sDat[i]};
        nRise++;
        if (nRise == 1) fr = ecnt;
      end
      pc = sClk[i];
      if (ce < 0 && ws[i] != w0) ce = ecnt;
      if (bsy[i] && !sDat[i]) zc++;
      if (rdy[i]) begin
        re = ecnt;
        break;
      end
    end
    if (re < 0) chk($sformatf("u%0d.frame_timeout", i), 0, 1);
  endtask

  task automatic pulseReset(int n);
    @(posedge CLK); #1 reset = 1'b1;
    repeat (n) @(posedge CLK);
    #1 reset = 1'b0;
  endtask

  initial begin
    int t1, t2, nR, fr, ce, re, zc;
    logic [47:0] dec1, dec2;
    logic [31:0] w;
    vld = 2'b00;
    dat[0] = '0; dat[1] = '0;
    cntBias[0] = '0; cntBias[1] = '0;

    // reset then idle
    reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("idle.readyA", rdy[0], 1);
    chk("idle.sdataA", sDat[0], 0);
    chk("idle.countA", ws[0], 0);
    chk("idle.sclkB", sClk[1], 0);

    // single word, word_data scrambled after accept
    sendWord(0, 32'hDEADBEEF, t1);
    measure(0, 1'b1, dec1, nR, fr, ce, re, zc);
    chk("single.decode", dec1, {32'hDEADBEEF, 16'hFAB1});
    chk("single.rises", nR, 48);
    chk("single.first_rise", fr - t1, 2);
    chk("single.count_edge", ce - t1, 192);
    chk("single.ready_edge", re - t1, 196);
    chk("single.count", ws[0], 1);

    // back-to-back with word_valid held high
    pulseReset(2);
    vld[0] = 1'b1; dat[0] = 32'h00000001;
    waitAccept(0, t1);
    dat[0] = 32'h80000000;
    measure(0, 1'b0, dec1, nR, fr, ce, re, zc);
    waitAccept(0, t2);
    vld[0] = 1'b0;
    measure(0, 1'b0, dec2, nR, fr, ce, re, zc);
    chk("b2b.period", t2 - t1, 197);
    chk("b2b.decode1", dec1, {32'h00000001, 16'hFAB1});
    chk("b2b.decode2", dec2, {32'h80000000, 16'hFAB1});
    chk("b2b.count", ws[0], 2);

    // minimum divider, zero gap
    sendWord(1, 32'hFFFFFFFF, t1);
    measure(1, 1'b0, dec1, nR, fr, ce, re, zc);
    chk("fast.decode", dec1, {32'hFFFFFFFF, 16'hFAB1});
    chk("fast.rises", nR, 48);
    chk("fast.first_rise", fr - t1, 1);
    chk("fast.ready_edge", re - t1, 96);
    chk("fast.zero_cycles", zc, 12);

    // reset mid-frame
    sendWord(0, 32'hCAFEF00D, t1);
    repeat (49) @(posedge CLK);
    #1 reset = 1'b1;
    #1;
    chk("midrst.sclk", sClk[0], 0);
    chk("midrst.sdata", sDat[0], 0);
    chk("midrst.ready", rdy[0], 1);
    chk("midrst.count", ws[0], 0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    sendWord(0, 32'h12345678, t1);
    measure(0, 1'b0, dec1, nR, fr, ce, re, zc);
    chk("midrst.decode", dec1, {32'h12345678, 16'hFAB1});
    chk("midrst.count_after", ws[0], 1);

    // words_sent wrap
    @(posedge CLK); #2;
    force dutB.words_sent = 16'hFFFF;
    cntBias[1] = 16'hFFFF;
    #1 release dutB.words_sent;
    @(negedge CLK);
    chk("wrap.preload", ws[1], 16'hFFFF);
    w = $urandom;
    sendWord(1, w, t1);
    measure(1, 1'b1, dec1, nR, fr, ce, re, zc);
    chk("wrap.decode", dec1, {w, 16'hFAB1});
    chk("wrap.count", ws[1], 0);

    // random traffic, valid toggling including while busy
    for (int n = 0; n < 3000; n++) begin
      @(posedge CLK); #1;
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 3) == 0);
        dat[i] = $urandom;
      end
    end
    vld = 2'b00;
    repeat (300) @(posedge CLK);
    #1;
    chk("end.readyA", rdy[0], 1);
    chk("end.readyB", rdy[1], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bitbang_tx.md
# bitbang_tx

Host-side serializer for the fabric configuration bit-bang port. It accepts 32-bit configuration words over a valid/ready handshake and drives `s_clk`/`s_data` so that the fabric's bit-bang receiver captures each word. Each word is followed by the control trailer that commits it as a configuration write. It sits in the test harness or in a companion controller outside the fabric, on the other end of the `s_clk`/`s_data` wires.

## Interface
Parameters:
- `CLK_DIV`, default 2: `CLK` cycles per `s_clk` half-period; legal values are 1 and above.
- `GAP_CYCLES`, default 4: idle `CLK` cycles inserted after each frame; 0 is legal.
- `CTRL_WORD`, default 16'hFAB1: 16-bit control trailer appended to every word.

Ports:
- `CLK`  input  1  system clock; all logic is on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `word_data`  input  32  configuration word to send.
- `word_valid`  input  1  `word_data` is valid.
- `word_ready`  output  1  block is idle and can accept a word.
- `s_clk`  output  1  bit-bang clock to the fabric.
- `s_data`  output  1  bit-bang data to the fabric.
- `busy`  output  1  a frame or gap is in progress.
- `words_sent`  output  16  count of completed frames; wraps modulo 2^16.

## Operation
- A frame is 48 bits, sent MSB first: `word_data[31:0]`, then `CTRL_WORD[15:0]`.
- The frame shift register is captured on accept; later changes on `word_data` have no effect.
- Accept occurs on a `CLK` edge where `word_valid` and `word_ready` are both 1.
- State machine: IDLE, LOW, HIGH, GAP.
  - IDLE: `word_ready`=1, `busy`=0, `s_clk`=0, `s_data`=0. On accept, go to LOW with bit index 47.
  - LOW: `s_clk`=0; `s_data` holds the current bit. Stay `CLK_DIV` cycles, then go to HIGH.
  - HIGH: `s_clk`=1; `s_data` is unchanged. Stay `CLK_DIV` cycles.
    - If the bit index is above 0: decrement it, shift, and go to LOW.
    - If the bit index is 0: increment `words_sent`, then go to GAP (or to IDLE when `GAP_CYCLES`=0).
  - GAP: `s_clk`=0, `s_data`=0. Stay `GAP_CYCLES` cycles, then go to IDLE.
- `s_data` changes only at the start of LOW (or on entry to GAP/IDLE). It is therefore stable for `CLK_DIV` cycles on both sides of every `s_clk` rising edge. The receiver samples on that rising edge.
- `word_valid` while not ready is ignored; no word is queued.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Timing
- Reset values of all outputs: `word_ready`=1, `busy`=0, `s_clk`=0, `s_data`=0, `words_sent`=0; state is IDLE.
- Let accept occur at edge T and D=`CLK_DIV`.
- Bit k (k=0 is `word_data[31]`) occupies cycles T+1+2kD through T+2(k+1)D:
  - `s_clk` is low for the first D cycles and high for the last D.
  - The rising edge of `s_clk` for bit k is at cycle T+1+2kD+D.
- `words_sent` increments at cycle T+96D+1 (the last HIGH cycle is T+96D).
- `word_ready` returns to 1 at cycle T+96D+`GAP_CYCLES`+1.
- `word_ready` drops to 0 at T+1. `busy` = NOT `word_ready` at all times.
- Back-to-back: if `word_valid` is held high, the next accept occurs on the first cycle `word_ready`=1. Frame period is 96D+`GAP_CYCLES`+1 cycles.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). The partial frame is dropped and `words_sent` does not increment for it. Normal operation resumes on the first edge after reset deasserts.
- `words_sent` at 16'hFFFF wraps to 0 on the next completion.
- Counter widths: the divide counter is sized for `CLK_DIV`; the gap counter is sized for `GAP_CYCLES` (min 1 bit); the bit index is 6 bits.

## Test plan
- Reset then idle:
  - Stimulus: assert `reset` for 3 cycles, release, hold `word_valid`=0 for 20 cycles.
  - Required: `word_ready`=1, `s_clk`=0, `s_data`=0, `words_sent`=0 throughout.
- Single word:
  - Stimulus: D=2, GAP=4; send 32'hDEADBEEF.
  - Required: exactly 48 `s_clk` rising edges. A model sampling `s_data` on those edges reconstructs 32'hDEADBEEF followed by 16'hFAB1. First rising edge at T+3; `words_sent`=1 at T+193; `word_ready`=1 at T+197.
- Back-to-back:
  - Stimulus: hold `word_valid` high with words 32'h00000001, then 32'h80000000.
  - Required: second accept exactly 197 cycles after the first; both frames decode correctly; `words_sent`=2.
- Zero gap and minimum divider:
  - Stimulus: D=1, GAP=0; send 32'hFFFFFFFF.
  - Required: `s_clk` toggles every cycle; `word_ready` returns at T+97; `s_data` is low only during trailer zero bits.
- Reset mid-frame:
  - Stimulus: assert `reset` at T+50.
  - Required: `s_clk`/`s_data` go to 0 in the same cycle; `words_sent` unchanged; a fresh 32'h12345678 afterwards decodes correctly.
- Input stability and wrap:
  - Stimulus: change `word_data` every cycle after accept; preload `words_sent` to 16'hFFFF via 65535 frames (or a bind/force).
  - Required: the frame carries the accept-time value; the next completion yields `words_sent`=0.
